// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit-side byte FIFO in front of a UART transmitter.
//
// CPU stores are pushed at up to one byte per clock into a circular buffer. A
// drain FSM (StIdle -> StSend -> StWait) launches one byte at a time into the
// UART using a single-cycle write strobe. It then waits for the UART busy flag
// to fall before launching the next byte.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   cpu_wr_en/data    one-cycle push strobe and byte from the store decode
//   clr_overflow      one-cycle strobe clearing the sticky overflow flag
//   full/empty/level  occupancy, decoded from the entry counter
//   overflow          sticky, set when a push is dropped on a full FIFO
//   idle              FIFO empty, FSM idle and UART not busy (flush complete)
//   uart_write_en     registered one-cycle launch strobe to the UART
//   uart_write_data   registered byte for the UART, held between strobes
//   uart_tx_busy      UART busy flag, rises the cycle after an accepted strobe
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_wr_en,
    input  logic [7:0]       cpu_wr_data,
    input  logic             clr_overflow,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic             idle,
    output logic             uart_write_en,
    output logic [7:0]       uart_write_data,
    input  logic             uart_tx_busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [LVL_W-1:0] count_q, count_d;
    logic             push, pop, drop;
    logic             wr_en_d;
    logic [7:0]       wr_data_d;
    logic             overflow_d;

    // Occupancy flags come from the registered counter only, so a pop in the
    // same cycle never rescues a push into a full FIFO.
    assign full  = (count_q == LVL_W'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign idle  = empty && (state_q == StIdle) && !uart_tx_busy;

    assign push = cpu_wr_en && !full;
    assign drop = cpu_wr_en && full;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!empty && !uart_tx_busy) state_d = StSend;
            StSend:  state_d = StWait;
            // A rejected strobe never raises busy, so this exits after one cycle.
            StWait:  if (!uart_tx_busy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath decode: the launch is registered, so the pop happens on
    // the same edge that raises the strobe.
    always_comb begin
        pop        = (state_q == StIdle) && !empty && !uart_tx_busy;
        wr_en_d    = pop;
        wr_data_d  = pop ? mem_q[tail_q] : uart_write_data;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        // A dropped push wins over a clear in the same cycle.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            overflow        <= 1'b0;
            uart_write_en   <= 1'b0;
            uart_write_data <= 8'h00;
        end else begin
            if (push) head_q <= head_q + PTR_W'(1);
            if (pop)  tail_q <= tail_q + PTR_W'(1);
            count_q         <= count_d;
            overflow        <= overflow_d;
            uart_write_en   <= wr_en_d;
            uart_write_data <= wr_data_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[head_q] <= cpu_wr_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. The bench contains a small UART busy
// model. A queue-based reference model tracks the accepted bytes, occupancy,
// the overflow flag and launch order.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cpu_wr_en = 1'b0;
    logic [7:0]       cpu_wr_data = 8'h00;
    logic             clr_overflow = 1'b0;
    logic             full, empty, overflow, idle;
    logic [LVL_W-1:0] level;
    logic             uart_write_en;
    logic [7:0]       uart_write_data;
    logic             uart_tx_busy;

    logic busy_m = 1'b0;
    logic force_busy = 1'b0;
    int   frame_len = 40;
    int   frame_cnt = 0;

    assign uart_tx_busy = busy_m | force_busy;

    uart_tx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_wr_en       (cpu_wr_en),
        .cpu_wr_data     (cpu_wr_data),
        .clr_overflow    (clr_overflow),
        .full            (full),
        .empty           (empty),
        .level           (level),
        .overflow        (overflow),
        .idle            (idle),
        .uart_write_en   (uart_write_en),
        .uart_write_data (uart_write_data),
        .uart_tx_busy    (uart_tx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // UART stand-in: busy for frame_len cycles after an accepted strobe.
    always @(posedge clk) begin
        if (rst) begin
            busy_m    <= 1'b0;
            frame_cnt <= 0;
        end else if (frame_cnt > 0) begin
            frame_cnt <= frame_cnt - 1;
            if (frame_cnt == 1) busy_m <= 1'b0;
        end else if (uart_write_en && !uart_tx_busy) begin
            busy_m    <= 1'b1;
            frame_cnt <= frame_len;
        end
    end

    // Inputs as seen by the DUT at each edge.
    logic       e_rst, e_wr, e_clr;
    logic [7:0] e_data;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        e_rst  <= rst;
        e_wr   <= cpu_wr_en;
        e_clr  <= clr_overflow;
        e_data <= cpu_wr_data;
    end

    // Reference model state
    logic [7:0] q[$];
    logic       ovf_m = 1'b0;
    logic       busy_last = 1'b0;
    bit         in_frame = 1'b0;
    int         due_cyc = -1;
    int         strobes = 0;
    int         accepted = 0;
    int         first_strobe_cyc = -1;
    int         max_level = 0;
    bit         m_full, busy_now, idle_exp;

    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            busy_now = uart_tx_busy;
            if (e_rst) begin
                q.delete();
                ovf_m    = 1'b0;
                in_frame = 1'b0;
                due_cyc  = -1;
                check("rst_wr_en", uart_write_en, 0);
                check("rst_wr_data", uart_write_data, 0);
            end else begin
                m_full = (q.size() == DEPTH);
                if (uart_write_en) begin
                    strobes++;
                    if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
                    check("strobe_while_busy", busy_last, 0);
                    if (q.size() == 0) check("spurious_strobe", uart_write_en, 0);
                    else check("tx_data", uart_write_data, q.pop_front());
                    if (due_cyc >= 0) check("spacing", cyc, due_cyc);
                    due_cyc  = -1;
                    in_frame = 1'b1;
                end else if (due_cyc == cyc) begin
                    check("spacing_strobe", uart_write_en, 1);
                    due_cyc = -1;
                end
                if (e_wr && !m_full) begin
                    q.push_back(e_data);
                    accepted++;
                end
                if (e_wr && m_full) ovf_m = 1'b1;
                else if (e_clr) ovf_m = 1'b0;
                // Busy fell on a frame we launched: next launch is two cycles on.
                if (in_frame && busy_last && !busy_now) begin
                    in_frame = 1'b0;
                    if (q.size() > 0) due_cyc = cyc + 2;
                end
            end
            check("level", level, q.size());
            check("empty", empty, q.size() == 0);
            check("full", full, q.size() == DEPTH);
            check("overflow", overflow, ovf_m);
            idle_exp = (q.size() == 0) && !busy_now && !uart_write_en && (e_rst || !busy_last);
            check("idle", idle, idle_exp);
            if (q.size() > max_level) max_level = q.size();
            busy_last = busy_now;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        cpu_wr_en   = 1'b1;
        cpu_wr_data = d;
        tick();
        cpu_wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (!(idle && q.size() == 0) && k < budget) begin
            tick();
            k++;
        end
        check("drain_timeout", k < budget, 1);
    endtask

    int c0, s0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Single byte launch latency
        frame_len = 40;
        first_strobe_cyc = -1;
        s0 = strobes;
        c0 = cyc;
        push(8'hA5);
        wait_drain(200);
        check("launch_latency", first_strobe_cyc, c0 + 2);
        check("single_count", strobes - s0, 1);
        check("idle_after", idle, 1);

        // Burst overflow against a long frame
        frame_len = 200;
        max_level = 0;
        s0 = strobes;
        for (int i = 0; i < 20; i++) push(8'(i));
        check("burst_overflow", overflow, 1);
        check("peak_level", max_level, DEPTH);
        wait_drain(5000);
        check("burst_count", strobes - s0, 17);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Overflow clear racing a rejected push
        frame_len = 8;
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
        check("race_full", full, 1);
        check("race_ovf_set", overflow, 1);
        cpu_wr_en = 1'b1;
        cpu_wr_data = 8'h5A;
        clr_overflow = 1'b1;
        tick();
        cpu_wr_en = 1'b0;
        clr_overflow = 1'b0;
        check("race_set_wins", overflow, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("race_clear", overflow, 0);
        force_busy = 1'b0;
        wait_drain(2000);

        // Busy back-pressure
        frame_len = 6;
        force_busy = 1'b1;
        s0 = strobes;
        for (int i = 0; i < 3; i++) push(8'($urandom));
        repeat (10) tick();
        check("bp_no_strobe", strobes - s0, 0);
        force_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("bp_release", uart_write_en, 1);
        tick();
        wait_drain(500);
        check("bp_count", strobes - s0, 3);

        // Wrap-around: 40 bytes in bursts of 10
        s0 = strobes;
        for (int b = 0; b < 4; b++) begin
            frame_len = $urandom_range(4, 12);
            for (int i = 0; i < 10; i++) push(8'($urandom));
            wait_drain(2000);
        end
        check("wrap_count", strobes - s0, 40);
        check("wrap_level", level, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) frame_len = $urandom_range(2, 10);
            cpu_wr_en    = 1'($urandom_range(0, 1));
            cpu_wr_data  = 8'($urandom);
            clr_overflow = ($urandom_range(0, 15) == 0);
            tick();
        end
        cpu_wr_en = 1'b0;
        clr_overflow = 1'b0;
        wait_drain(5000);
        check("rand_count", strobes, accepted);

        // Reset during SEND with bytes still queued
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
        repeat (2) tick();
        force_busy = 1'b0;
        tick();
        check("rst_send_strobe", uart_write_en, 1);
        check("rst_send_level", level, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_wr_en", uart_write_en, 0);
        check("rst_mid_level", level, 0);
        check("rst_mid_empty", empty, 1);
        check("rst_mid_idle", idle, 1);
        s0 = strobes;
        repeat (50) tick();
        check("rst_no_strobe", strobes - s0, 0);
        push(8'hC3);
        wait_drain(200);
        check("rst_recover", strobes - s0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

endmodule
